// File: rtl/u_rec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : u_rec_pkg
// Brief    : Shared receiver FSM states, 3-sample majority vote and parameter
//            range check for u_rec_param (optional parity: U_REC_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
package u_rec_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BRK    = 3'd5
   } rec_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic bit params_ok(input int data_bits,
                                    input int oversample,
                                    input int stop_bits);
      return (data_bits >= 5) && (data_bits <= 9) &&
             (oversample >= 8) && (oversample <= 64) && ((oversample % 2) == 0) &&
             ((stop_bits == 1) || (stop_bits == 2));
   endfunction

endpackage
`default_nettype wire

// File: rtl/u_rec_if.sv
`default_nettype none
// ============================================================================
// Module   : u_rec_if
// Brief    : Receive-word handshake bundle between u_rec_param and consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface u_rec_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rec_dataH;
   logic                 rec_validH;
   logic                 rec_readyH;
   logic                 frame_errH;
   logic                 par_errH;
   logic                 overrunH;

   modport master (
      output rec_dataH, rec_validH, frame_errH, par_errH, overrunH,
      input  rec_readyH
   );

   modport slave (
      input  rec_dataH, rec_validH, frame_errH, par_errH, overrunH,
      output rec_readyH
   );
endinterface
`default_nettype wire

// File: rtl/u_rec_sampler.sv
`default_nettype none
// ============================================================================
// Module   : u_rec_sampler
// Brief    : Line synchroniser, per-bit tick counter and 3-sample majority vote.
// Revision : 1.0 - initial release
// ============================================================================
module u_rec_sampler
   import u_rec_pkg::*;
#(
   parameter int OVERSAMPLE = 16
)(
   input  logic clk_i,
   input  logic rst_i,
   input  logic sample_en_i,
   input  logic line_i,
   input  logic run_i,
   output logic line_sync_o,
   output logic bit_strobe_o,
   output logic bit_value_o
);
   localparam int unsigned     c_TW        = $clog2(OVERSAMPLE);
   localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(OVERSAMPLE - 1);
   localparam logic [c_TW-1:0] c_TICK_PRE  = c_TW'(OVERSAMPLE / 2 - 1);
   localparam logic [c_TW-1:0] c_TICK_MID  = c_TW'(OVERSAMPLE / 2);
   localparam logic [c_TW-1:0] c_TICK_VOTE = c_TW'(OVERSAMPLE / 2 + 1);

   logic            sync1_q, sync2_q;
   logic [c_TW-1:0] tick_q, tick_d;
   logic            smp_pre_q, smp_pre_d;
   logic            smp_mid_q, smp_mid_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         tick_q    <= '0;
         smp_pre_q <= 1'b1;
         smp_mid_q <= 1'b1;
      end else begin
         sync1_q   <= line_i;
         sync2_q   <= sync1_q;
         tick_q    <= tick_d;
         smp_pre_q <= smp_pre_d;
         smp_mid_q <= smp_mid_d;
      end
   end

   // run_i follows the FSM's next state, so the start-detect sample is tick 0
   always_comb begin
      tick_d    = tick_q;
      smp_pre_d = smp_pre_q;
      smp_mid_d = smp_mid_q;
      if (sample_en_i) begin
         if (!run_i || (tick_q == c_TICK_LAST)) begin
            tick_d = '0;
         end else begin
            tick_d = tick_q + 1'b1;
         end
         if (tick_q == c_TICK_PRE) begin
            smp_pre_d = sync2_q;
         end
         if (tick_q == c_TICK_MID) begin
            smp_mid_d = sync2_q;
         end
      end
   end

   assign line_sync_o  = sync2_q;
   assign bit_strobe_o = sample_en_i && (tick_q == c_TICK_VOTE);
   assign bit_value_o  = maj3(smp_pre_q, smp_mid_q, sync2_q);

endmodule
`default_nettype wire

// File: rtl/u_rec_param.sv
`default_nettype none
// ============================================================================
// Module   : u_rec_param
// Brief    : Parametrised UART receiver with valid/ready output, framing and
//            overrun reporting, break recovery. Parity via U_REC_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module u_rec_param
   import u_rec_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1
)(
   input  logic     sys_clk,
   input  logic     sys_rst,
   input  logic     sample_en,
   input  logic     uart_dataH,
`ifdef U_REC_PARITY_EN
   input  logic     parity_oddH,
`endif
   u_rec_if.master  rec_if
);
   localparam int unsigned     c_BW        = $clog2(DATA_BITS + 1);
   localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_BITS - 1);
   localparam logic            c_STOP_LAST = 1'(STOP_BITS - 1);

   if (!params_ok(DATA_BITS, OVERSAMPLE, STOP_BITS)) begin : g_param_check
      $error("u_rec_param: DATA_BITS/OVERSAMPLE/STOP_BITS out of range");
   end

   rec_state_e           state_q, state_d;
   logic [c_BW-1:0]      bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 ferr_q, ferr_d;
   logic [DATA_BITS-1:0] rec_data_q, rec_data_d;
   logic                 rec_valid_q, rec_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
`ifdef U_REC_PARITY_EN
   logic                 perr_q, perr_d;
   logic                 par_err_q, par_err_d;
`endif

   logic w_line_sync, w_bit_strobe, w_bit_value, w_run;
   logic w_deliver, w_frame_flag, w_handshake;

   u_rec_sampler #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_sampler (
      .clk_i        (sys_clk),
      .rst_i        (sys_rst),
      .sample_en_i  (sample_en),
      .line_i       (uart_dataH),
      .run_i        (w_run),
      .line_sync_o  (w_line_sync),
      .bit_strobe_o (w_bit_strobe),
      .bit_value_o  (w_bit_value)
   );

   assign w_run = (state_d != ST_IDLE) && (state_d != ST_BRK);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         ferr_q     <= 1'b0;
`ifdef U_REC_PARITY_EN
         perr_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         ferr_q     <= ferr_d;
`ifdef U_REC_PARITY_EN
         perr_q     <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      shift_d      = shift_q;
      ferr_d       = ferr_q;
`ifdef U_REC_PARITY_EN
      perr_d       = perr_q;
`endif
      w_deliver    = 1'b0;
      w_frame_flag = ferr_q | ~w_bit_value;
      case (state_q)
         ST_IDLE: begin
            if (sample_en && !w_line_sync) begin
               state_d    = ST_START;
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
               ferr_d     = 1'b0;
`ifdef U_REC_PARITY_EN
               perr_d     = 1'b0;
`endif
            end
         end
         ST_START: begin
            if (w_bit_strobe) begin
               state_d = w_bit_value ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_bit_strobe) begin
               shift_d = {w_bit_value, shift_q[DATA_BITS-1:1]};
               if (bit_cnt_q == c_BIT_LAST) begin
                  bit_cnt_d = '0;
`ifdef U_REC_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
`ifdef U_REC_PARITY_EN
         ST_PARITY: begin
            if (w_bit_strobe) begin
               perr_d  = ((^shift_q) ^ w_bit_value) != parity_oddH;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (w_bit_strobe) begin
               if (!w_bit_value) begin
                  ferr_d = 1'b1;
               end
               if (stop_cnt_q == c_STOP_LAST) begin
                  w_deliver  = 1'b1;
                  stop_cnt_d = 1'b0;
                  state_d    = w_frame_flag ? ST_BRK : ST_IDLE;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         ST_BRK: begin
            // A held-low line after a bad stop must not be mistaken for a start bit
            if (sample_en && w_line_sync) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign w_handshake = rec_valid_q & rec_if.rec_readyH;

   always_comb begin
      rec_data_d  = rec_data_q;
      rec_valid_d = rec_valid_q;
      frame_err_d = frame_err_q;
`ifdef U_REC_PARITY_EN
      par_err_d   = par_err_q;
`endif
      overrun_d   = 1'b0;
      if (w_deliver && (!rec_valid_q || w_handshake)) begin
         rec_data_d  = shift_q;
         rec_valid_d = 1'b1;
         frame_err_d = w_frame_flag;
`ifdef U_REC_PARITY_EN
         par_err_d   = perr_q;
`endif
      end else begin
         if (w_deliver) begin
            overrun_d = 1'b1;
         end
         if (w_handshake) begin
            rec_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rec_data_q  <= '0;
         rec_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef U_REC_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         rec_data_q  <= rec_data_d;
         rec_valid_q <= rec_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef U_REC_PARITY_EN
         par_err_q   <= par_err_d;
`endif
      end
   end

   assign rec_if.rec_dataH  = rec_data_q;
   assign rec_if.rec_validH = rec_valid_q;
   assign rec_if.frame_errH = frame_err_q;
   assign rec_if.overrunH   = overrun_q;
`ifdef U_REC_PARITY_EN
   assign rec_if.par_errH   = par_err_q;
`else
   assign rec_if.par_errH   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_u_rec_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_u_rec_param
// Brief    : Directed + random frames into an 8N1 and a 5-data/2-stop receiver,
//            compared against a frame-level model (U_REC_PARITY_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_u_rec_param;
   localparam int OS     = 16;
   localparam int MID    = OS / 2;
   localparam int SE_DIV = 4;
`ifdef U_REC_PARITY_EN
   localparam int PBITS  = 1;
`else
   localparam int PBITS  = 0;
`endif

   typedef struct {
      logic [8:0] data;
      logic       ferr;
      logic       perr;
      int         idx;
   } ev_t;

   logic sys_clk   = 1'b0;
   logic sys_rst   = 1'b1;
   logic sample_en = 1'b0;
   logic line8     = 1'b1;
   logic line5     = 1'b1;
`ifdef U_REC_PARITY_EN
   logic parity_odd = 1'b0;
`endif
   int   div     = 0;
   int   se_cnt  = 0;
   int   checks  = 0;
   int   errors  = 0;
   int   ov8     = 0;
   int   ov5     = 0;
   logic p8_valid = 1'b0, p8_hs = 1'b0, p5_valid = 1'b0, p5_hs = 1'b0;
   ev_t  q8[$];
   ev_t  q5[$];

   u_rec_if #(.DATA_BITS(8)) if8 ();
   u_rec_if #(.DATA_BITS(5)) if5 ();

   u_rec_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut8 (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .sample_en   (sample_en),
      .uart_dataH  (line8),
`ifdef U_REC_PARITY_EN
      .parity_oddH (parity_odd),
`endif
      .rec_if      (if8)
   );

   u_rec_param #(.DATA_BITS(5), .OVERSAMPLE(OS), .STOP_BITS(2)) dut5 (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .sample_en   (sample_en),
      .uart_dataH  (line5),
`ifdef U_REC_PARITY_EN
      .parity_oddH (parity_odd),
`endif
      .rec_if      (if5)
   );

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      div       <= (div + 1) % SE_DIV;
      sample_en <= (((div + 1) % SE_DIV) == 0);
   end

   always @(posedge sys_clk) begin
      if (sample_en) se_cnt <= se_cnt + 1;
   end

   function automatic ev_t mk_ev(input logic [8:0] d, input logic f, input logic p, input int i);
      ev_t e;
      e.data = d; e.ferr = f; e.perr = p; e.idx = i;
      return e;
   endfunction

   // Observer: a new word is on offer when valid is high and was not already held
   always @(negedge sys_clk) begin
      if (sys_rst) begin
         p8_valid <= 1'b0; p8_hs <= 1'b0; p5_valid <= 1'b0; p5_hs <= 1'b0;
      end else begin
         if (if8.rec_validH && (!p8_valid || p8_hs))
            q8.push_back(mk_ev(9'(if8.rec_dataH), if8.frame_errH, if8.par_errH, se_cnt));
         if (if5.rec_validH && (!p5_valid || p5_hs))
            q5.push_back(mk_ev(9'(if5.rec_dataH), if5.frame_errH, if5.par_errH, se_cnt));
         if (if8.overrunH) ov8 <= ov8 + 1;
         if (if5.overrunH) ov5 <= ov5 + 1;
         p8_valid <= if8.rec_validH;
         p8_hs    <= if8.rec_validH && if8.rec_readyH;
         p5_valid <= if5.rec_validH;
         p5_hs    <= if5.rec_validH && if5.rec_readyH;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_se();
      @(posedge sys_clk);
      while (sample_en !== 1'b1) @(posedge sys_clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) wait_se();
   endtask

   task automatic set_line(input bit to5, input logic v);
      if (to5) line5 = v;
      else     line8 = v;
   endtask

   // Serialises one frame bit by bit, OS strobes per bit; returns the index of
   // the strobe at which the receiver first sees the start bit.
   task automatic send_frame(input bit to5, input logic [8:0] data, input logic stop_val,
                             input logic par_flip, input int nsend, output int start_idx);
      logic bits[$];
      int   nb, ns, n;
      logic p;
      nb = to5 ? 5 : 8;
      ns = to5 ? 2 : 1;
      bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) bits.push_back(data[i]);
`ifdef U_REC_PARITY_EN
      p = parity_odd ^ par_flip;
      for (int i = 0; i < nb; i++) p = p ^ data[i];
      bits.push_back(p);
`else
      p = par_flip;
`endif
      for (int s = 0; s < ns; s++) bits.push_back(stop_val);
      n = (nsend < 0 || nsend > bits.size()) ? bits.size() : nsend;
      wait_se();
      start_idx = se_cnt + 1;
      for (int k = 0; k < n; k++) begin
         set_line(to5, bits[k]);
         repeat (OS) wait_se();
      end
   endtask

   task automatic expect_event(input bit to5, input logic [8:0] data, input logic ferr,
                               input logic perr, input int start_idx, input string tag);
      int  nb, ns, n;
      ev_t e;
      nb = to5 ? 5 : 8;
      ns = to5 ? 2 : 1;
      n  = to5 ? q5.size() : q8.size();
      check({tag, " words"}, n, 1);
      if (n >= 1) begin
         if (to5) e = q5.pop_front();
         else     e = q8.pop_front();
         check({tag, " data"},    e.data, data);
         check({tag, " ferr"},    e.ferr, ferr);
         check({tag, " perr"},    e.perr, perr);
         check({tag, " latency"}, e.idx - start_idx, OS * (nb + PBITS + ns) + MID + 1);
      end
      if (to5) q5.delete();
      else     q8.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " v8"}, if8.rec_validH, 0);
      check({tag, " d8"}, if8.rec_dataH,  0);
      check({tag, " f8"}, {if8.frame_errH, if8.par_errH, if8.overrunH}, 0);
      check({tag, " v5"}, if5.rec_validH, 0);
      check({tag, " d5"}, if5.rec_dataH,  0);
      check({tag, " f5"}, {if5.frame_errH, if5.par_errH, if5.overrunH}, 0);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int       st, st2, ov_base;
      logic [8:0] d;
      logic     sv;

      if8.rec_readyH = 1'b1;
      if5.rec_readyH = 1'b1;
      repeat (6) @(posedge sys_clk);
      #1;
      check_reset_outputs("reset");
      sys_rst = 1'b0;
      idle(4);

      // Basic 8N1 word
      send_frame(0, 9'h0A5, 1'b1, 1'b0, -1, st);
      expect_event(0, 9'h0A5, 1'b0, 1'b0, st, "a5");
      check("a5 valid one cycle", if8.rec_validH, 0);

      // Short low glitch must be rejected
      wait_se();
      line8 = 1'b0;
      repeat (4) wait_se();
      line8 = 1'b1;
      idle(2 * OS);
      check("glitch no word", q8.size(), 0);
      send_frame(0, 9'h03C, 1'b1, 1'b0, -1, st);
      expect_event(0, 9'h03C, 1'b0, 1'b0, st, "3c");

      // Bad stop bit, then held-low break
      send_frame(0, 9'h0FF, 1'b0, 1'b0, -1, st);
      expect_event(0, 9'h0FF, 1'b1, 1'b0, st, "ff ferr");
      idle(3 * OS);
      check("break no word", q8.size(), 0);
      line8 = 1'b1;
      idle(OS);
      send_frame(0, 9'h096, 1'b1, 1'b0, -1, st);
      expect_event(0, 9'h096, 1'b0, 1'b0, st, "after break");

`ifdef U_REC_PARITY_EN
      parity_odd = 1'b0;
      send_frame(0, 9'h007, 1'b1, 1'b1, -1, st);
      expect_event(0, 9'h007, 1'b0, 1'b1, st, "par bad");
      send_frame(0, 9'h007, 1'b1, 1'b0, -1, st);
      expect_event(0, 9'h007, 1'b0, 1'b0, st, "par good");
      parity_odd = 1'b1;
      send_frame(0, 9'h0C3, 1'b1, 1'b0, -1, st);
      expect_event(0, 9'h0C3, 1'b0, 1'b0, st, "odd good");
      parity_odd = 1'b0;
`endif

      // Overrun: consumer stalled across two frames
      if8.rec_readyH = 1'b0;
      ov_base = ov8;
      send_frame(0, 9'h011, 1'b1, 1'b0, -1, st);
      idle(3);
      send_frame(0, 9'h022, 1'b1, 1'b0, -1, st2);
      idle(2);
      check("ovr pulses", ov8 - ov_base, 1);
      check("ovr held data", if8.rec_dataH, 9'h011);
      check("ovr held valid", if8.rec_validH, 1);
      expect_event(0, 9'h011, 1'b0, 1'b0, st, "ovr first");
      if8.rec_readyH = 1'b1;
      @(posedge sys_clk);
      #1;
      check("ovr drained", if8.rec_validH, 0);
      check("ovr no new word", q8.size(), 0);

      // Random frames, occasional bad stop bit
      for (int i = 0; i < 6; i++) begin
         d  = 9'($urandom_range(0, 255));
         sv = ($urandom_range(0, 3) != 0);
         idle($urandom_range(1, 20));
         send_frame(0, d, sv, 1'b0, -1, st);
         expect_event(0, d, !sv, 1'b0, st, "rand8");
         line8 = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         d  = 9'($urandom_range(0, 31));
         sv = ($urandom_range(0, 3) != 0);
         idle($urandom_range(1, 20));
         send_frame(1, d, sv, 1'b0, -1, st);
         expect_event(1, d, !sv, 1'b0, st, "rand5");
         line5 = 1'b1;
      end
      check("no overrun while ready", ov5 + ov8 - ov_base, 1);

      // Reset in the middle of a 5-bit frame
      idle(2);
      send_frame(1, 9'h00A, 1'b1, 1'b0, 3, st);
      sys_rst = 1'b1;
      line5   = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;
      check_reset_outputs("midreset");
      sys_rst = 1'b0;
      idle(2 * OS);
      check("midreset no word", q5.size(), 0);
      send_frame(1, 9'h015, 1'b1, 1'b0, -1, st);
      expect_event(1, 9'h015, 1'b0, 1'b0, st, "15 after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
